// File: rtl/regfile_sb_if.sv
// Operand-fetch / write-back bundle for regfile_sb.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is combinational and does not depend
// on req_valid. The master must hold its request fields stable while
// req_valid is high and req_ready is low. out_valid is a one-cycle pulse
// with no backpressure: the consumer takes out_data in that cycle.
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NRD   = 4,
  parameter int NWR   = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 req_valid;
  logic                 req_ready;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       zero_mask;
  logic                 const_sel;
  logic [WIDTH-1:0]     constant;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 out_valid;
  logic [NRD*WIDTH-1:0] out_data;
  logic [DEPTH-1:0]     pending;

  modport master (
    output req_valid, rd_addr, zero_mask, const_sel, constant,
           rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    input  req_ready, out_valid, out_data, pending
  );

  modport slave (
    input  req_valid, rd_addr, zero_mask, const_sel, constant,
           rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    output req_ready, out_valid, out_data, pending
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, highest-port-wins
// write conflict resolution and a pending-write scoreboard that stalls
// operand fetch on read-after-write hazards.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NRD   = 4,
  parameter int NWR   = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]     pending_q;
  logic [DEPTH-1:0]     pending_d;
  logic                 out_valid_q;
  logic [NRD*WIDTH-1:0] out_data_q;

  logic [AW-1:0]        ra [NRD];
  logic [AW-1:0]        wa [NWR];
  logic [WIDTH-1:0]     wd [NWR];
  logic [NWR-1:0]       wr_ok;
  logic [WIDTH-1:0]     slot_val [NRD];
  logic [NRD-1:0]       hit;
  logic [NRD-1:0]       hazard;
  logic [NRD*WIDTH-1:0] slot_pack;
  logic                 accept;

  // Addresses beyond DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Unpack the flat read/write buses into per-port arrays.
  always_comb begin
    for (int i = 0; i < NRD; i++) ra[i] = bus.rd_addr[i*AW +: AW];
    for (int j = 0; j < NWR; j++) begin
      wa[j] = bus.wr_addr[j*AW +: AW];
      wd[j] = bus.wr_data[j*WIDTH +: WIDTH];
    end
  end

  // A write only counts when it targets a real register.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWR; j++) wr_ok[j] = bus.wr_en[j] && in_range(wa[j]);
  end

  // Per-slot source mux and hazard detection; later write ports override
  // earlier ones so the bypass matches the array's conflict rule.
  always_comb begin
    hit       = '0;
    hazard    = '0;
    slot_pack = '0;
    for (int i = 0; i < NRD; i++) begin
      slot_val[i] = in_range(ra[i]) ? mem[ra[i]] : '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j] && (wa[j] == ra[i])) begin
          hit[i]      = 1'b1;
          slot_val[i] = wd[j];
        end
      end
      if (bus.zero_mask[i]) begin
        slot_val[i] = '0;
      end else if ((i == 0) && bus.const_sel) begin
        slot_val[i] = bus.constant;
      end
      hazard[i] = !bus.zero_mask[i] && !((i == 0) && bus.const_sel) &&
                  in_range(ra[i]) && pending_q[ra[i]] && !hit[i];
      slot_pack[i*WIDTH +: WIDTH] = slot_val[i];
    end
  end

  assign bus.req_ready = ~|hazard;
  assign accept        = bus.req_valid && bus.req_ready;

  // Scoreboard update: writes clear, an accepted reservation sets and wins.
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) pending_d[wa[j]] = 1'b0;
    end
    if (accept && bus.rsv_valid && in_range(bus.rsv_addr)) begin
      pending_d[bus.rsv_addr] = 1'b1;
    end
  end

  // Register array; the highest-indexed port targeting a register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wa[j] == AW'(r))) mem[r] <= wd[j];
        end
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Operand output register; data holds when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) out_data_q <= slot_pack;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pending   = pending_q;
endmodule
